// File: rtl/fpu_issue_ctrl_if.sv
// Operation/handshake bundle between the EX-stage FPU issue controller and its surroundings
// (core pipeline control plus FPU enable/result bus).
interface fpu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       fpuOp;
    logic             flush;
    logic [WIDTH-1:0] fpuResult;
    logic             fpu_sel;
    logic             stall;
    logic [WIDTH-1:0] result_q;
    logic             result_valid;
    logic [31:0]      perf_cycles;
    logic [31:0]      perf_ops;

    // master: the issue controller itself; slave: core pipeline and FPU around it
    modport master (
        input  start, fpuOp, flush, fpuResult,
        output fpu_sel, stall, result_q, result_valid, perf_cycles, perf_ops
    );

    modport slave (
        output start, fpuOp, flush, fpuResult,
        input  fpu_sel, stall, result_q, result_valid, perf_cycles, perf_ops
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// EX-stage FPU issue controller: one op in flight, fpu_sel held for the op latency, result captured.
// Optional performance counters are enabled with the FPU_PERF_CNT_EN macro.
module fpu_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_CMP  = 1,
    parameter int LAT_CVT  = 6,
    parameter int CNT_W    = 5
) (
    input logic              clock,
    input logic              clear,
    fpu_issue_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] L_ADD  = CNT_W'(LAT_ADD);
    localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(LAT_DIV);
    localparam logic [CNT_W-1:0] L_SQRT = CNT_W'(LAT_SQRT);
    localparam logic [CNT_W-1:0] L_CMP  = CNT_W'(LAT_CMP);
    localparam logic [CNT_W-1:0] L_CVT  = CNT_W'(LAT_CVT);
    localparam logic [CNT_W-1:0] L_FMA  = CNT_W'(LAT_MUL + LAT_ADD);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             issue;
    logic             fpu_sel_r;
    logic             result_valid_r;
    logic [WIDTH-1:0] result_q_r;

    always_comb begin
        lat = '0;
        case (bus.fpuOp)
            4'd0, 4'd1:                 lat = L_ADD;
            4'd2:                       lat = L_MUL;
            4'd3:                       lat = L_DIV;
            4'd5, 4'd7:                 lat = L_CMP;
            4'd6:                       lat = L_SQRT;
            4'd8, 4'd9:                 lat = L_CVT;
            4'd10, 4'd11, 4'd12, 4'd13: lat = L_FMA;
            default:                    lat = '0;
        endcase
    end

    assign issue = (state == IDLE) && bus.start && !bus.flush;

    // Stall must rise in the issue cycle and drop in the same cycle a flush arrives, hence combinational
    assign bus.stall = (issue && (lat != '0)) || ((state == RUN) && !bus.flush);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state          <= IDLE;
            cnt            <= '0;
            fpu_sel_r      <= 1'b0;
            result_q_r     <= '0;
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (lat != '0) begin
                            cnt       <= lat;
                            fpu_sel_r <= 1'b1;
                            state     <= RUN;
                        end else begin
                            result_q_r     <= bus.fpuResult;
                            result_valid_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        cnt       <= '0;
                        fpu_sel_r <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // fpu_sel stays high through this cycle so the FPU output is still valid at capture
                    cnt       <= '0;
                    fpu_sel_r <= 1'b0;
                    state     <= IDLE;
                    if (!bus.flush) begin
                        result_q_r     <= bus.fpuResult;
                        result_valid_r <= 1'b1;
                    end
                end
                default: begin
                    cnt       <= '0;
                    fpu_sel_r <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.fpu_sel      = fpu_sel_r;
    assign bus.result_q     = result_q_r;
    assign bus.result_valid = result_valid_r;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_ops_r;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            perf_cycles_r <= '0;
            perf_ops_r    <= '0;
        end else begin
            if (fpu_sel_r) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if (result_valid_r) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end
        end
    end

    assign bus.perf_cycles = perf_cycles_r;
    assign bus.perf_ops    = perf_ops_r;
`else
    assign bus.perf_cycles = 32'd0;
    assign bus.perf_ops    = 32'd0;
`endif

    a_valid_after_release : assert property (
        @(posedge clock) disable iff (clear) result_valid_r |-> !fpu_sel_r
    );

    a_run_count_live : assert property (
        @(posedge clock) disable iff (clear) (state == RUN) |-> (cnt != '0)
    );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: per-cycle pipeline-control model plus a result queue popped by a monitor.
// Perf counter expectations follow the FPU_PERF_CNT_EN macro.
module tb_fpu_issue_ctrl;

    logic clock;
    logic clear;

    fpu_issue_ctrl_if #(.WIDTH(32)) bus ();

    fpu_issue_ctrl dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;
    logic [31:0] last_result;
    int          model_cycles;
    int          model_ops;
    int          lat_table [16] = '{7, 7, 5, 6, 0, 1, 16, 1, 6, 6, 12, 12, 12, 12, 0, 0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding expected result
    always @(negedge clock) begin
        if (!clear && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected result_valid: got pulse with result_q 0x%08h, expected no pulse",
                         bus.result_q);
            end else begin
                exp_val = exp_q.pop_front();
                checkOutput("scoreboard result_q", bus.result_q, exp_val);
            end
        end
    end

    // One op from the idle state; flush_at < 0 means no flush, otherwise flush during cycle flush_at
    task automatic applyStimulus(input int op, input logic [31:0] capture, input int flush_at);
        int lat;
        int f_eff;
        int hold_end;
        int cap_k;
        int rv_k;
        bit flushed;
        bit exp_stall;
        bit exp_sel;
        bit exp_rv;
        lat      = lat_table[op];
        f_eff    = (flush_at < 0) ? 1000 : flush_at;
        hold_end = (lat == 0) ? 0 : lat + 1;
        cap_k    = (lat == 0) ? 0 : lat + 1;
        rv_k     = cap_k + 1;
        flushed  = (flush_at >= 0) && (flush_at <= cap_k);
        for (int k = 0; k <= rv_k; k++) begin
            bus.start = (k <= hold_end) && (k <= f_eff);
            bus.flush = (k == flush_at);
            bus.fpuOp = 4'(op);
            if (k == cap_k && !flushed) begin
                bus.fpuResult = capture;
                exp_q.push_back(capture);
                last_result = capture;
            end else begin
                bus.fpuResult = $urandom;
            end
            exp_stall = (lat > 0) && (k <= lat) && (k < f_eff);
            exp_sel   = (lat > 0) && (k >= 1) && (k <= lat + 1) && (k <= f_eff);
            exp_rv    = !flushed && (k == rv_k);
            if (exp_sel) model_cycles++;
            if (exp_rv) model_ops++;
            @(negedge clock);
            checkOutput($sformatf("op%0d flush%0d k%0d stall", op, flush_at, k), 32'(bus.stall), 32'(exp_stall));
            checkOutput($sformatf("op%0d flush%0d k%0d fpu_sel", op, flush_at, k), 32'(bus.fpu_sel), 32'(exp_sel));
            checkOutput($sformatf("op%0d flush%0d k%0d result_valid", op, flush_at, k),
                        32'(bus.result_valid), 32'(exp_rv));
            @(posedge clock);
            #1;
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic checkPerf(input string tag);
`ifdef FPU_PERF_CNT_EN
        checkOutput({tag, " perf_cycles"}, bus.perf_cycles, 32'(model_cycles));
        checkOutput({tag, " perf_ops"}, bus.perf_ops, 32'(model_ops));
`else
        checkOutput({tag, " perf_cycles"}, bus.perf_cycles, 32'd0);
        checkOutput({tag, " perf_ops"}, bus.perf_ops, 32'd0);
`endif
    endtask

    initial begin
        int op;
        int flush_at;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.fpuOp     = 4'd0;
        bus.fpuResult = 32'd0;
        clear         = 1'b1;
        model_cycles  = 0;
        model_ops     = 0;
        last_result   = 32'd0;

        @(negedge clock);
        checkOutput("reset stall", 32'(bus.stall), 32'd0);
        checkOutput("reset fpu_sel", 32'(bus.fpu_sel), 32'd0);
        checkOutput("reset result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("reset result_q", bus.result_q, 32'd0);
        checkPerf("reset");
        @(posedge clock);
        #1;
        clear = 1'b0;

        applyStimulus(2, 32'h40C00000, -1);
        checkOutput("mul result_q", bus.result_q, 32'h40C00000);
        applyStimulus(6, $urandom, -1);
        applyStimulus(4, 32'hBF800000, -1);
        checkOutput("sign-inject result_q", bus.result_q, 32'hBF800000);
        applyStimulus(12, $urandom, 5);
        checkOutput("flushed fma result_q held", bus.result_q, last_result);
        applyStimulus(7, $urandom, 0);
        applyStimulus(3, $urandom, 7);
        checkOutput("flush in done result_q held", bus.result_q, last_result);

        // Asynchronous clear in the middle of a divide
        bus.start     = 1'b1;
        bus.fpuOp     = 4'd3;
        bus.fpuResult = $urandom;
        @(posedge clock);
        #1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        clear     = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("clear stall", 32'(bus.stall), 32'd0);
        checkOutput("clear fpu_sel", 32'(bus.fpu_sel), 32'd0);
        checkOutput("clear result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("clear result_q", bus.result_q, 32'd0);
        model_cycles = 0;
        model_ops    = 0;
        last_result  = 32'd0;
        checkPerf("clear");
        @(posedge clock);
        #1;
        clear = 1'b0;

        applyStimulus(0, $urandom, -1);
        applyStimulus(7, $urandom, -1);
`ifdef FPU_PERF_CNT_EN
        checkOutput("add+cmp perf_cycles", bus.perf_cycles, 32'd10);
        checkOutput("add+cmp perf_ops", bus.perf_ops, 32'd2);
`endif
        checkPerf("add+cmp");

        repeat (40) begin
            op = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) begin
                flush_at = $urandom_range(0, lat_table[op] + 1);
            end else begin
                flush_at = -1;
            end
            applyStimulus(op, $urandom, flush_at);
        end
        checkOutput("random final result_q", bus.result_q, last_result);
        checkPerf("random");
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
